life_board: RTL and testbench

Owns the 8x8 toroidal Game of Life board and advances it one generation per tick. It sits directly downstream of the mode controller and consumes its one-hot mode outputs `rst`, `strt` and `rnd`. It also runs the 64-bit LFSR used for random seeding, and drives the board image to the display stage.

---
 rtl/life_pkg.sv | 27 ++
 rtl/life_board_row_calc.sv | 33 +++
 rtl/life_board.sv | 106 ++++++++++
 tb/tb_life_board.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared constants, FSM state type and LFSR step for the 8x8 toroidal Life board.
package life_pkg;

   localparam int SIDE  = 8;
   localparam int CELLS = SIDE * SIDE;

   typedef enum logic [1:0] {
      HOLD   = 2'd0,
      WAIT   = 2'd1,
      CALC   = 2'd2,
      COMMIT = 2'd3
   } life_state_t;

   localparam logic [CELLS-1:0] DEFAULT_SEED = 64'h0412_6424_0034_3C28;

   localparam int TAP_A = 63;
   localparam int TAP_B = 62;
   localparam int TAP_C = 60;
   localparam int TAP_D = 59;

   // A stuck-at-zero register restarts from the init value instead of locking up.
   function automatic logic [63:0] lfsr_step(input logic [63:0] q, input logic [63:0] init);
      if (q == '0) return init;
      return {q[62:0], q[TAP_A] ^ q[TAP_B] ^ q[TAP_C] ^ q[TAP_D]};
   endfunction

endpackage

// File: rtl/life_board_row_calc.sv
// Next-generation value of one board row, with column wrap-around.
module life_row_calc
   import life_pkg::*;
(
   input  logic [SIDE-1:0] above,
   input  logic [SIDE-1:0] cur,
   input  logic [SIDE-1:0] below,
   output logic [SIDE-1:0] next_row
);

   // Rotated copies: *_l[c] is column c-1, *_r[c] is column c+1.
   logic [SIDE-1:0] above_l, above_r, cur_l, cur_r, below_l, below_r;

   assign above_l = {above[SIDE-2:0], above[SIDE-1]};
   assign above_r = {above[0], above[SIDE-1:1]};
   assign cur_l   = {cur[SIDE-2:0], cur[SIDE-1]};
   assign cur_r   = {cur[0], cur[SIDE-1:1]};
   assign below_l = {below[SIDE-2:0], below[SIDE-1]};
   assign below_r = {below[0], below[SIDE-1:1]};

   always_comb begin
      logic [3:0] cnt;
      cnt      = '0;
      next_row = '0;
      for (int c = 0; c < SIDE; c++) begin
         cnt = 4'(above_l[c]) + 4'(above[c]) + 4'(above_r[c])
             + 4'(cur_l[c])                  + 4'(cur_r[c])
             + 4'(below_l[c]) + 4'(below[c]) + 4'(below_r[c]);
         next_row[c] = (cnt == 4'd3) || (cur[c] && (cnt == 4'd2));
      end
   end

endmodule

// File: rtl/life_board.sv
// 8x8 toroidal Game of Life board: generation FSM, tick timer, seeding LFSR.
//
// state  | meaning
// HOLD   | idle; board/gen_count/tick frozen unless rst or rnd acts
// WAIT   | counting TICK_DIV cycles between generations
// CALC   | one row per cycle into next_buf, rows 0..7
// COMMIT | next_buf -> board, gen_count++, gen_done pulse
module life_board
   import life_pkg::*;
#(
   parameter int               TICK_DIV  = 50_000_000,
   parameter logic [CELLS-1:0] SEED      = DEFAULT_SEED,
   parameter logic [63:0]      LFSR_INIT = 64'h0000_0000_0000_0001
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             rst,
   input  logic             strt,
   input  logic             rnd,
   output logic [CELLS-1:0] board,
   output logic [15:0]      gen_count,
   output logic             busy,
   output logic             gen_done
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   life_state_t      state;
   logic [TW-1:0]    tick;
   logic [2:0]       row;
   logic [63:0]      lfsr;
   logic [63:0]      lfsr_next;
   logic [CELLS-1:0] next_buf;
   logic [SIDE-1:0]  row_above, row_cur, row_below, row_next;

   assign lfsr_next = lfsr_step(lfsr, LFSR_INIT);

   assign row_above = board[{row - 3'd1, 3'b000} +: SIDE];
   assign row_cur   = board[{row,        3'b000} +: SIDE];
   assign row_below = board[{row + 3'd1, 3'b000} +: SIDE];

   life_row_calc u_row_calc (
      .above    (row_above),
      .cur      (row_cur),
      .below    (row_below),
      .next_row (row_next)
   );

   always_ff @(posedge clk) begin
      gen_done <= 1'b0;
      if (!reset_n) begin
         board     <= SEED;
         lfsr      <= LFSR_INIT;
         gen_count <= '0;
         tick      <= '0;
         row       <= '0;
         state     <= HOLD;
         busy      <= 1'b0;
      end else begin
         lfsr <= lfsr_next;
         if (rst) begin
            board     <= SEED;
            gen_count <= '0;
            tick      <= '0;
            state     <= HOLD;
            busy      <= 1'b0;
         end else if (rnd) begin
            board <= lfsr_next;
            tick  <= '0;
            state <= HOLD;
            busy  <= 1'b0;
         end else if (strt) begin
            unique case (state)
               HOLD: state <= WAIT;
               WAIT: begin
                  if (tick == TICK_LAST) begin
                     tick  <= '0;
                     row   <= '0;
                     state <= CALC;
                     busy  <= 1'b1;
                  end else begin
                     tick <= tick + 1'b1;
                  end
               end
               CALC: begin
                  next_buf[{row, 3'b000} +: SIDE] <= row_next;
                  row <= row + 3'd1;
                  if (row == 3'd7) state <= COMMIT;
               end
               COMMIT: begin
                  board     <= next_buf;
                  gen_count <= (gen_count == 16'hFFFF) ? gen_count : gen_count + 16'd1;
                  gen_done  <= 1'b1;
                  state     <= WAIT;
                  busy      <= 1'b0;
               end
            endcase
         end else begin
            state <= HOLD;
            busy  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_life_board.sv
// Directed bench for life_board: blinker, torus wrap, empty board, randomize, abort, reset mid-commit.
module tb_life_board;

   localparam int          TD     = 4;
   localparam logic [63:0] SEED_A = 64'h0000_0000_1C00_0000;
   localparam logic [63:0] GEN1_A = 64'h0000_0008_0808_0000;
   localparam logic [63:0] SEED_B = 64'h8100_0000_0000_0081;
   localparam logic [63:0] SEED_C = 64'h0;

   typedef struct packed {
      logic [63:0] board;
      logic [15:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n [3];
   logic        rst     [3];
   logic        strt    [3];
   logic        rnd     [3];
   logic [63:0] board_o [3];
   logic [15:0] count_o [3];
   logic        busy_o  [3];
   logic        done_o  [3];

   exp_t        sb [$];
   int          checks = 0;
   int          errors = 0;
   logic [63:0] lf_a;

   always #5 clk = ~clk;

   life_board #(.TICK_DIV(TD), .SEED(SEED_A), .LFSR_INIT(64'h1)) dut_a (
      .clk(clk), .reset_n(reset_n[0]), .rst(rst[0]), .strt(strt[0]), .rnd(rnd[0]),
      .board(board_o[0]), .gen_count(count_o[0]), .busy(busy_o[0]), .gen_done(done_o[0]));

   life_board #(.TICK_DIV(TD), .SEED(SEED_B), .LFSR_INIT(64'h1)) dut_b (
      .clk(clk), .reset_n(reset_n[1]), .rst(rst[1]), .strt(strt[1]), .rnd(rnd[1]),
      .board(board_o[1]), .gen_count(count_o[1]), .busy(busy_o[1]), .gen_done(done_o[1]));

   life_board #(.TICK_DIV(TD), .SEED(SEED_C), .LFSR_INIT(64'h1)) dut_c (
      .clk(clk), .reset_n(reset_n[2]), .rst(rst[2]), .strt(strt[2]), .rnd(rnd[2]),
      .board(board_o[2]), .gen_count(count_o[2]), .busy(busy_o[2]), .gen_done(done_o[2]));

   function automatic logic [63:0] lfsr_model(input logic [63:0] q);
      if (q == 64'h0) return 64'h1;
      return {q[62:0], q[63] ^ q[62] ^ q[60] ^ q[59]};
   endfunction

   // Reference LFSR for dut_a, stepping on every edge.
   always @(posedge clk) lf_a <= !reset_n[0] ? 64'h1 : lfsr_model(lf_a);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Waits for a gen_done pulse, then checks latency, busy cycles and the scoreboard entry.
   task automatic wait_gen(input int idx, input int exp_lat, input string tag);
      int   n = 0;
      int   nbusy = 0;
      exp_t e;
      do begin
         @(negedge clk);
         n++;
         if (busy_o[idx]) nbusy++;
      end while (!done_o[idx] && n < 40);
      chk({tag, " latency"}, 64'(n), 64'(exp_lat));
      chk({tag, " busy cycles"}, 64'(nbusy), 64'd9);
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s scoreboard: observed empty queue expected an entry", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, " board"}, board_o[idx], e.board);
         chk({tag, " gen_count"}, 64'(count_o[idx]), 64'(e.cnt));
      end
   endtask

   initial begin
      exp_t e;
      int   ndone;
      for (int i = 0; i < 3; i++) begin
         reset_n[i] = 1'b0;
         rst[i]     = 1'b0;
         strt[i]    = 1'b0;
         rnd[i]     = 1'b0;
      end
      repeat (2) @(negedge clk);
      chk("reset board", board_o[0], SEED_A);
      chk("reset gen_count", 64'(count_o[0]), 64'd0);
      chk("reset busy", 64'(busy_o[0]), 64'd0);
      chk("reset gen_done", 64'(done_o[0]), 64'd0);

      // randomize straight out of reset
      reset_n[0] = 1'b1;
      rnd[0]     = 1'b1;
      @(negedge clk);
      chk("rnd 1", board_o[0], 64'd2);
      @(negedge clk);
      chk("rnd 2", board_o[0], 64'd4);
      @(negedge clk);
      chk("rnd 3", board_o[0], 64'd8);
      rnd[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("rnd hold", board_o[0], 64'd8);
      chk("rnd gen_count", 64'(count_o[0]), 64'd0);

      rst[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      chk("clear board", board_o[0], SEED_A);

      // blinker, two generations
      sb.push_back('{GEN1_A, 16'd1});
      sb.push_back('{SEED_A, 16'd2});
      strt[0] = 1'b1;
      wait_gen(0, TD + 10, "blink1");
      wait_gen(0, TD + 9, "blink2");

      // abort in the 4th CALC cycle
      repeat (TD + 3) @(negedge clk);
      chk("abort in calc", 64'(busy_o[0]), 64'd1);
      rnd[0] = 1'b1;
      sb.push_back('{lfsr_model(lf_a), 16'd2});
      @(negedge clk);
      rnd[0]  = 1'b0;
      strt[0] = 1'b0;
      e = sb.pop_front();
      chk("abort board", board_o[0], e.board);
      chk("abort gen_count", 64'(count_o[0]), 64'(e.cnt));
      chk("abort gen_done", 64'(done_o[0]), 64'd0);
      chk("abort busy", 64'(busy_o[0]), 64'd0);
      ndone = 0;
      repeat (20) begin
         @(negedge clk);
         if (done_o[0]) ndone++;
      end
      chk("abort no pulse", 64'(ndone), 64'd0);
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      chk("post abort board", board_o[0], SEED_A);
      chk("post abort gen_count", 64'(count_o[0]), 64'd0);

      // reset asserted in the COMMIT cycle
      strt[0] = 1'b1;
      repeat (TD + 9) @(negedge clk);
      chk("commit busy", 64'(busy_o[0]), 64'd1);
      reset_n[0] = 1'b0;
      @(negedge clk);
      chk("mid commit board", board_o[0], SEED_A);
      chk("mid commit gen_done", 64'(done_o[0]), 64'd0);
      chk("mid commit busy", 64'(busy_o[0]), 64'd0);
      chk("mid commit gen_count", 64'(count_o[0]), 64'd0);
      reset_n[0] = 1'b1;
      sb.push_back('{GEN1_A, 16'd1});
      wait_gen(0, TD + 10, "post reset");
      strt[0] = 1'b0;

      // 2x2 block across the torus corners is a still life
      reset_n[1] = 1'b1;
      @(negedge clk);
      chk("torus seed", board_o[1], SEED_B);
      for (int g = 1; g <= 3; g++) sb.push_back('{SEED_B, 16'(g)});
      strt[1] = 1'b1;
      wait_gen(1, TD + 10, "torus1");
      wait_gen(1, TD + 9, "torus2");
      wait_gen(1, TD + 9, "torus3");
      strt[1] = 1'b0;

      // empty board stays empty while generations keep counting
      reset_n[2] = 1'b1;
      @(negedge clk);
      chk("empty seed", board_o[2], SEED_C);
      for (int g = 1; g <= 3; g++) sb.push_back('{SEED_C, 16'(g)});
      strt[2] = 1'b1;
      wait_gen(2, TD + 10, "empty1");
      wait_gen(2, TD + 9, "empty2");
      wait_gen(2, TD + 9, "empty3");
      strt[2] = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
